// File: rtl/run_length_reporter.sv
// Measures the length of every high run on a detector output and queues each
// completed length in a small FWFT FIFO drained over a valid/ready handshake.
module run_length_reporter #(
    parameter int CNT_W = 8,
    parameter int AW    = 2
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             det_in,
    output logic [CNT_W-1:0] len_data,
    output logic             len_valid,
    input  logic             len_ready,
    output logic [AW:0]      fifo_count,
    output logic             overflow
);

    localparam int               DEPTH     = 2**AW;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1'b1);
    localparam logic [AW:0]      FCNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0]      FCNT_FULL = (AW+1)'(DEPTH);

    logic             det_d_r;
    logic [CNT_W-1:0] run_cnt_r;
    logic [CNT_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      count_r;
    logic             overflow_r;

    logic push_s;
    logic pop_s;
    logic full_s;
    logic wr_en_s;
    logic drop_s;

    // Length counter clamps at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    // Handshake and push/drop decisions for the current edge.
    always_comb begin
        push_s  = 1'b0;
        pop_s   = 1'b0;
        full_s  = 1'b0;
        wr_en_s = 1'b0;
        drop_s  = 1'b0;
        push_s  = det_d_r & ~det_in;
        pop_s   = len_valid & len_ready;
        full_s  = (count_r == FCNT_FULL);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        wr_en_s = push_s & (~full_s | pop_s);
        drop_s  = push_s & full_s & ~pop_s;
    end

    // Run tracking, FIFO storage and sticky overflow.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            det_d_r    <= 1'b0;
            run_cnt_r  <= '0;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            det_d_r <= det_in;
            if (det_in) begin
                if (det_d_r) begin
                    run_cnt_r <= sat_inc(run_cnt_r);
                end else begin
                    run_cnt_r <= CNT_ONE;
                end
            end else begin
                run_cnt_r <= run_cnt_r;
            end

            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= run_cnt_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end

            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + FCNT_ONE;
                2'b01:   count_r <= count_r - FCNT_ONE;
                default: count_r <= count_r;
            endcase

            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign len_data   = mem_r[rd_ptr_r];
    assign len_valid  = (count_r != '0);
    assign fifo_count = count_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_run_length_reporter.sv
// Scoreboard bench for run_length_reporter: a behavioural queue model predicts
// the FIFO contents each cycle, and directed scenarios check the reported lengths.
module tb_run_length_reporter;

    logic       CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       det_in = 1'b0;
    logic [7:0] len_data;
    logic       len_valid;
    logic       len_ready = 1'b0;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    int m_q[$];
    bit m_det_d = 1'b0;
    int m_run = 0;
    bit m_ovf = 1'b0;

    int dut_got[$];
    int valid_cycles = 0;

    run_length_reporter #(.CNT_W(8), .AW(2)) dut (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .det_in     (det_in),
        .len_data   (len_data),
        .len_valid  (len_valid),
        .len_ready  (len_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, log DUT handshakes, advance the model, compare.
    task automatic step(input bit din, input bit rdy, input bit rstn);
        int size_before;
        bit pop;
        bit push;
        det_in    = din;
        len_ready = rdy;
        reset_n   = rstn;
        if (rstn && len_valid === 1'b1) begin
            valid_cycles++;
            if (rdy) dut_got.push_back(int'(len_data));
        end
        @(posedge CLK);
        if (!rstn) begin
            m_q.delete();
            m_det_d = 1'b0;
            m_run   = 0;
            m_ovf   = 1'b0;
        end else begin
            size_before = m_q.size();
            pop  = (size_before != 0) && rdy;
            push = m_det_d && !din;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (size_before < 4 || pop) m_q.push_back(m_run);
                else m_ovf = 1'b1;
            end
            if (din) m_run = m_det_d ? ((m_run < 255) ? m_run + 1 : 255) : 1;
            m_det_d = din;
        end
        #1;
        check_eq("len_valid", {31'd0, len_valid}, {31'd0, (m_q.size() != 0)});
        check_eq("fifo_count", {29'd0, fifo_count}, m_q.size());
        check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (m_q.size() != 0) check_eq("len_data", {24'd0, len_data}, m_q[0]);
    endtask

    task automatic clear_log();
        dut_got.delete();
        valid_cycles = 0;
    endtask

    task automatic run(input int len, input bit rdy);
        for (int i = 0; i < len; i++) step(1'b1, rdy, 1'b1);
        step(1'b0, rdy, 1'b1);
    endtask

    initial begin
        // 1: reset held with activity, then a 2-long run
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check_eq("rst_len_data", {24'd0, len_data}, 32'd0);
        end
        clear_log();
        run(2, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        check_eq("t1_reports", dut_got.size(), 32'd1);
        if (dut_got.size() >= 1) check_eq("t1_len", dut_got[0], 32'd2);

        // 2: single 5-long run, valid for one cycle only
        clear_log();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_eq("t2_valid_next", {31'd0, len_valid}, 32'd1);
        check_eq("t2_data_next", {24'd0, len_data}, 32'd5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        check_eq("t2_valid_cycles", valid_cycles, 32'd1);
        check_eq("t2_count_end", {29'd0, fifo_count}, 32'd0);

        // 3: saturation
        clear_log();
        run(300, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        check_eq("t3_reports", dut_got.size(), 32'd1);
        if (dut_got.size() >= 1) check_eq("t3_len", dut_got[0], 32'd255);
        check_eq("t3_overflow", {31'd0, overflow}, 32'd0);

        // 4: five runs into a stalled FIFO
        clear_log();
        for (int r = 1; r <= 5; r++) run(r, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("t4_count", {29'd0, fifo_count}, 32'd4);
        check_eq("t4_overflow", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1);
        check_eq("t4_reports", dut_got.size(), 32'd4);
        for (int i = 0; i < 4 && i < dut_got.size(); i++) check_eq("t4_order", dut_got[i], i + 1);
        check_eq("t4_valid_end", {31'd0, len_valid}, 32'd0);
        check_eq("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

        // 5: push into a full FIFO with a simultaneous pop
        step(1'b0, 1'b0, 1'b0);
        clear_log();
        for (int r = 0; r < 4; r++) run(1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_eq("t5_count", {29'd0, fifo_count}, 32'd4);
        check_eq("t5_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1);
        check_eq("t5_reports", dut_got.size(), 32'd5);
        if (dut_got.size() == 5) begin
            check_eq("t5_head", dut_got[0], 32'd1);
            check_eq("t5_last", dut_got[4], 32'd6);
        end

        // 6: reset mid-run discards the partial run
        clear_log();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        check_eq("t6_reports", dut_got.size(), 32'd1);
        if (dut_got.size() >= 1) check_eq("t6_len", dut_got[0], 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/run_length_reporter.md
# run_length_reporter

Downstream consumer of the two-consecutive-ones Moore detector. It measures the length, in clock cycles, of every contiguous high run on the detector's output. It queues each completed length in a small first-word-fall-through FIFO. Lengths are delivered to the next stage over a valid/ready handshake, with saturation and sticky overflow reporting.

## Interface
- CNT_W, 8: width of run-length counter and of len_data.
- AW, 2: FIFO address width; FIFO depth DEPTH = 2**AW (4 by default).

- CLK  input  1  rising-edge clock; the only clock.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- det_in  input  1  detector output; sampled every CLK edge.
- len_data  output  CNT_W  length at FIFO head.
- len_valid  output  1  FIFO non-empty; len_data is meaningful.
- len_ready  input  1  consumer accepts the head entry this cycle.
- fifo_count  output  AW+1  number of queued entries, 0..DEPTH.
- overflow  output  1  sticky; set when a completed length is dropped because the FIFO is full.

## Operation
- det_d is a 1-bit register holding det_in from the previous edge. run_cnt is a CNT_W-bit register.
- Run tracking, evaluated at each edge from det_d and det_in:
  - det_d=0, det_in=1: run_cnt <= 1 (new run).
  - det_d=1, det_in=1: run_cnt <= run_cnt+1, saturating at 2**CNT_W-1. It never wraps.
  - det_d=1, det_in=0: push request with data = run_cnt. run_cnt is then don't-care until the next run start.
  - det_d=0, det_in=0: idle.
- Reported length = number of consecutive edges at which det_in was sampled 1. Minimum 1; maximum 2**CNT_W-1 (saturated).
- FIFO: DEPTH-entry circular buffer with read/write pointers that wrap modulo DEPTH.
  - len_data = mem[rd_ptr] (first-word-fall-through).
  - len_valid = (fifo_count != 0).
- Pop = len_valid && len_ready. Pop while empty is ignored.
- Push handling:
  - Push while not full: accepted.
  - Push while full with pop in the same cycle: accepted; fifo_count is unchanged.
  - Push while full without pop: entry dropped; overflow <= 1; fifo_count unchanged.
- overflow stays 1 until reset. No other clear path exists.
- len_data is held stable while len_valid=1 and len_ready=0.
- Reset (reset_n=0 at an edge) does all of the following, regardless of any other input:
  - det_d, run_cnt, pointers, fifo_count, overflow and all memory entries go to 0.
  - Any run in progress is discarded and produces no report.

## Timing
- Reset values: len_data=0, len_valid=0, fifo_count=0, overflow=0.
- First edge with reset_n=1 and det_in=1 starts a new run of length 1, because det_d=0 after reset.
- Push latency: the write occurs at the edge where det_in is first sampled 0 after a run. len_valid and the updated fifo_count are visible in the following cycle. There is no same-cycle bypass from det_in to len_data.
- Pop: the handshake completes at the edge where len_valid=1 and len_ready=1. The next entry, or len_valid=0, is presented after that edge.
- Back-to-back runs separated by a single low cycle each produce a separate report.
- Simultaneous push and pop on an empty FIFO cannot occur: len_valid=0 blocks the pop, and the push is accepted.
- Throughput is one pop per cycle. The minimum push spacing is 2 cycles, because every run needs at least one high and one low sample.

## Test plan
1. Hold reset_n=0 for 3 edges with det_in=1 and len_ready=1. Required: len_valid=0, fifo_count=0, overflow=0, len_data=0 throughout. After release, det_in=1 for 2 edges then 0 produces exactly one report with len_data=2.
2. len_ready=1; det_in high for 5 edges, then low. Required: len_valid=1 for exactly one cycle, starting the cycle after the first low sample, with len_data=5; fifo_count then returns to 0.
3. CNT_W=8; det_in high for 300 edges, then low. Required: a single report with len_data=255; overflow=0.
4. len_ready=0; runs of length 1, 2, 3, 4, 5, each separated by one low cycle. Required: fifo_count=4, overflow=1 after the fifth run ends. Then len_ready=1: pops 1, 2, 3, 4 on consecutive cycles, len_valid=0 afterwards, and overflow remains 1.
5. Fill the FIFO with 4 entries (len_ready=0); assert len_ready=1 in the same cycle a 6-cycle run ends. Required: fifo_count stays 4, overflow=0, and the drained order ends with 6.
6. det_in high for 3 edges; reset_n=0 for one edge while det_in stays high; release with det_in high for 2 more edges, then low. Required: exactly one report, len_data=2; no report of 3 or 5.
